wb_byte_master: RTL and testbench
=================================

// Module: wb_byte_master
// PURPOSE
// - Wishbone initiator driven by a byte stream; responder side of the peripheral map (GPIO/PWM/UART/ring).
// - Parses command frames from a byte source (UART RX or LA), runs one single-beat classic WB cycle, returns status/data bytes.
// - Output port drives the master side of the peripheral mux, as a debug/bring-up path beside Caravel.
// PARAMETERS
// - TIMEOUT_CYCLES  255  bus cycles to wait for ack/err before abort (used only with WBM_TIMEOUT_EN); legal 1..65535
// PORTS
// - wb_clk_i     in   1   single clock
// - wb_rst_ni    in   1   reset, asynchronous assert, active-low
// - rx_data_i    in   8   command byte
// - rx_valid_i   in   1   rx_data_i valid
// - rx_ready_o   out  1   byte accepted when rx_valid_i & rx_ready_o
// - tx_data_o    out  8   response byte
// - tx_valid_o   out  1   tx_data_o valid
// - tx_ready_i   in   1   byte consumed when tx_valid_o & tx_ready_i
// - wbm_adr_o    out  32  WB address
// - wbm_dat_o    out  32  WB write data
// - wbm_dat_i    in   32  WB read data
// - wbm_sel_o    out  4   byte selects, always 4'hf during a cycle
// - wbm_we_o     out  1   write enable
// - wbm_cyc_o    out  1   cycle
// - wbm_stb_o    out  1   strobe
// - wbm_ack_i    in   1   ack
// - wbm_err_i    in   1   error
// - busy_o       out  1   high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE; rx_ready_o goes to 1 on the first clock after reset release.
// - Frame: opcode, 4 address bytes MSB first; write opcode then 4 data bytes MSB first. Opcodes 0x57 write, 0x52 read.
// - FSM IDLE -> ADDR (4 bytes) -> [DATA (4 bytes), write only] -> BUS -> RESP -> IDLE. 2-bit byte counter.
// - rx_ready_o=1 only in IDLE/ADDR/DATA; state advances only on accepted bytes; stalls hold everything.
// - Unknown opcode in IDLE: consume it, go to RESP, return status 0x03; no bus cycle.
// - BUS: cyc/stb/we/adr/dat/sel registered, asserted the cycle after the last frame byte is accepted.
//   Held stable until ack or err is sampled; cyc/stb drop the next cycle (no back-to-back beats).
//   ack: status 0x00, read latches wbm_dat_i that cycle. err: status 0x01. ack and err together: err wins.
// - RESP: write -> 1 byte (status). Read -> 5 bytes: status, then data MSB first; data 0 when status != 0x00.
//   tx_valid_o first rises the cycle after BUS exits; tx_data_o stable while tx_valid_o & ~tx_ready_i.
//   After last byte consumed -> IDLE; rx_ready_o returns next cycle. No rx bytes accepted in BUS/RESP.
// - Reset mid-frame or mid-cycle: cyc/stb drop immediately (async); partial frame discarded, no response.
// - All outputs registered; no combinational path rx->tx or wbm_ack_i->wbm_stb_o.
// CONFIGURATION
// - Macro WBM_TIMEOUT_EN defined: counter clears on entry to BUS, increments per BUS cycle; ack/err not seen
//   within TIMEOUT_CYCLES cycles -> drop cyc/stb, status 0x02. ack/err on the expiring cycle takes priority.
// - Macro not defined: no counter; BUS waits indefinitely for ack/err; status 0x02 never produced.
// STRUCTURE
// - Package wbm_byte_pkg: OP_WRITE=8'h57, OP_READ=8'h52, ST_OK=8'h00, ST_ERR=8'h01, ST_TIMEOUT=8'h02,
//   ST_BADOP=8'h03, state enum {IDLE, ADDR, DATA, BUS, RESP}.
// - Sub-module wbm_timeout_ctr (instantiated only under WBM_TIMEOUT_EN): clear/enable in, expired out.
// - Frame parsing, bus control and response serialiser stay in the top FSM.
// TESTING
// - Write: 57 30 80 00 04 DE AD BE EF; slave acks after 2 cycles -> one beat adr=3080_0004 dat=DEADBEEF we=1
//   sel=f; tx 00.
// - Read: 52 30 81 00 00; slave returns 0000_1234 with ack -> we=0; tx 00 00 00 12 34.
// - Err: read with wbm_err_i=1 and wbm_ack_i=1 in the same cycle -> tx 01 00 00 00 00.
// - Bad opcode 0xAA -> tx 03, wbm_cyc_o never asserted; next valid frame runs normally.
// - Backpressure: rx_valid_i gaps and tx_ready_i toggling every other cycle -> identical bus beat and bytes.
//   tx_data_o held while stalled.
// - WBM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles, tx 02. Without the macro, cyc stays
//   high; wb_rst_ni low mid-cycle -> cyc/stb 0 at once, no tx.

Source files
------------

// File: rtl/wbm_byte_pkg.sv
// wbm_byte_pkg: opcodes, status codes and FSM states shared by the byte-driven Wishbone master.
package wbm_byte_pkg;
    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'h03;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
endpackage

// File: rtl/wbm_timeout_ctr.sv
// wbm_timeout_ctr: counts bus cycles and flags the last allowed one.
module wbm_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    logic [15:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (en) count <= count + 16'd1;
    end
    assign expired = en && (count == 16'(LIMIT - 1));
endmodule

// File: rtl/wb_byte_master.sv
// wb_byte_master: byte-stream command parser driving single classic Wishbone beats; WBM_TIMEOUT_EN adds a bus timeout.
module wb_byte_master
    import wbm_byte_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);
    state_t      state;
    logic [1:0]  cnt;
    logic        wr;
    logic        dphase;
    logic [31:0] rdata;
    logic        expired;
    logic        rx_fire;
    logic        tx_fire;
    assign rx_fire = rx_valid_i & rx_ready_o;
    assign tx_fire = tx_valid_o & tx_ready_i;
`ifdef WBM_TIMEOUT_EN
    wbm_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk(wb_clk_i),
        .rst_n(wb_rst_ni),
        .clear(state != BUS),
        .en(state == BUS),
        .expired(expired)
    );
`else
    assign expired = (TIMEOUT_CYCLES == 0);
`endif
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            wr         <= 1'b0;
            dphase     <= 1'b0;
            rdata      <= '0;
            rx_ready_o <= 1'b0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready_o <= 1'b1;
                    if (rx_fire) begin
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        dphase <= 1'b0;
                        // anything but a read answers with a single status byte
                        wr     <= rx_data_i != OP_READ;
                        if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                            state <= ADDR;
                        end else begin
                            state      <= RESP;
                            rx_ready_o <= 1'b0;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= ST_BADOP;
                        end
                    end
                end
                ADDR: if (rx_fire) begin
                    wbm_adr_o <= {wbm_adr_o[23:0], rx_data_i};
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        if (wr) begin
                            state <= DATA;
                        end else begin
                            state      <= BUS;
                            rx_ready_o <= 1'b0;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            wbm_sel_o  <= 4'hf;
                            wbm_we_o   <= 1'b0;
                        end
                    end
                end
                DATA: if (rx_fire) begin
                    wbm_dat_o <= {wbm_dat_o[23:0], rx_data_i};
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state      <= BUS;
                        rx_ready_o <= 1'b0;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        wbm_sel_o  <= 4'hf;
                        wbm_we_o   <= 1'b1;
                    end
                end
                BUS: if (wbm_ack_i || wbm_err_i || expired) begin
                    state      <= RESP;
                    wbm_cyc_o  <= 1'b0;
                    wbm_stb_o  <= 1'b0;
                    wbm_sel_o  <= '0;
                    wbm_we_o   <= 1'b0;
                    tx_valid_o <= 1'b1;
                    cnt        <= '0;
                    dphase     <= 1'b0;
                    tx_data_o  <= wbm_err_i ? ST_ERR : (wbm_ack_i ? ST_OK : ST_TIMEOUT);
                    rdata      <= (wbm_ack_i && !wbm_err_i && !wr) ? wbm_dat_i : '0;
                end
                RESP: if (tx_fire) begin
                    if (wr || (dphase && cnt == 2'd3)) begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        tx_valid_o <= 1'b0;
                        rx_ready_o <= 1'b1;
                    end else begin
                        tx_data_o <= rdata[31:24];
                        rdata     <= {rdata[23:0], 8'h00};
                        dphase    <= 1'b1;
                        cnt       <= dphase ? cnt + 2'd1 : cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_byte_master.sv
// tb_wb_byte_master: directed frames with hand-computed bus beats and response bytes.
module tb_wb_byte_master;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic [3:0]  wbm_sel;
    logic        wbm_we;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;
    logic        busy;
    int checks = 0;
    int fails = 0;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic        cyc_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) if (wbm_cyc) cyc_seen <= 1'b1;

    wb_byte_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .busy_o(busy)
    );

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 50 && !rx_ready; n++) @(negedge clk);
        if (!rx_ready) begin
            checks++; fails++;
            $display("FAIL rx_wait rx_ready=%b required 1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[9], input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            send_byte(f[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic bus_beat(input int delay, input logic a, input logic e, input logic [31:0] rd);
        for (int n = 0; n < 50 && !wbm_cyc; n++) begin @(posedge clk); #1; end
        checks++;
        if (!wbm_cyc) begin
            fails++;
            $display("FAIL bus_start cyc=%b required 1", wbm_cyc);
            return;
        end
        cap_adr = wbm_adr; cap_dat = wbm_dat_o; cap_we = wbm_we; cap_sel = wbm_sel;
        repeat (delay) begin
            @(posedge clk); #1;
            checks++;
            if (wbm_cyc !== 1'b1 || wbm_stb !== 1'b1 || wbm_adr !== cap_adr || wbm_dat_o !== cap_dat) begin
                fails++;
                $display("FAIL bus_hold cyc=%b stb=%b adr=%h required cyc=1 stb=1 adr=%h", wbm_cyc, wbm_stb, wbm_adr, cap_adr);
            end
        end
        wbm_ack = a; wbm_err = e; wbm_dat_i = rd;
        @(posedge clk); #1;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_i = '0;
        checks++;
        if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0 || tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL bus_end cyc=%b stb=%b tx_valid=%b required 0 0 1", wbm_cyc, wbm_stb, tx_valid);
        end
    endtask

    task automatic recv_byte(input bit stall, output logic [7:0] b);
        logic [7:0] held;
        tx_ready = 1'b0;
        for (int n = 0; n < 50 && !tx_valid; n++) begin @(posedge clk); #1; end
        if (!tx_valid) begin
            checks++; fails++;
            $display("FAIL tx_wait tx_valid=%b required 1", tx_valid);
            b = 8'hxx;
            return;
        end
        if (stall) begin
            held = tx_data;
            @(posedge clk); #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
                fails++;
                $display("FAIL tx_hold tx_valid=%b tx_data=%h required 1 %h", tx_valid, tx_data, held);
            end
        end
        b = tx_data;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic recv_resp(input int len, input bit stall, output logic [39:0] got);
        logic [7:0] b;
        got = '0;
        for (int i = 0; i < len; i++) begin
            recv_byte(stall, b);
            got = {got[31:0], b};
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || wbm_cyc !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle busy=%b rx_ready=%b tx_valid=%b cyc=%b required 0 1 0 0", name, busy, rx_ready, tx_valid, wbm_cyc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o, tx_valid, tx_data, rx_ready, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs cyc=%b stb=%b adr=%h tx_valid=%b rx_ready=%b busy=%b required all 0",
                     wbm_cyc, wbm_stb, wbm_adr, tx_valid, rx_ready, busy);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_rx_ready_early rx_ready=%b required 0", rx_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rx_ready rx_ready=%b required 1", rx_ready);
        end
    endtask

    task automatic do_write(input string name, input int gap, input bit stall);
        logic [7:0] f[9] = '{8'h57, 8'h30, 8'h80, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [39:0] got;
        send_frame(f, 9, gap);
        checks++;
        if (wbm_cyc !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_cyc_start cyc=%b rx_ready=%b busy=%b required 1 0 1", name, wbm_cyc, rx_ready, busy);
        end
        bus_beat(2, 1'b1, 1'b0, 32'h0);
        checks++;
        if (cap_adr !== 32'h3080_0004 || cap_dat !== 32'hDEAD_BEEF || cap_we !== 1'b1 || cap_sel !== 4'hf) begin
            fails++;
            $display("FAIL %s_beat adr=%h dat=%h we=%b sel=%h required 30800004 deadbeef 1 f", name, cap_adr, cap_dat, cap_we, cap_sel);
        end
        recv_resp(1, stall, got);
        checks++;
        if (got[7:0] !== 8'h00) begin
            fails++;
            $display("FAIL %s_status got=%h required 00", name, got[7:0]);
        end
        check_idle(name);
    endtask

    task automatic do_read(input string name, input logic [7:0] a0, input int gap, input bit stall,
                           input logic a, input logic e, input logic [31:0] rd, input logic [39:0] exp);
        logic [7:0] f[9] = '{8'h52, 8'h30, 8'h81, 8'h00, a0, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [39:0] got;
        send_frame(f, 5, gap);
        bus_beat(1, a, e, rd);
        checks++;
        if (cap_adr !== {24'h308100, a0} || cap_we !== 1'b0 || cap_sel !== 4'hf) begin
            fails++;
            $display("FAIL %s_beat adr=%h we=%b sel=%h required %h 0 f", name, cap_adr, cap_we, cap_sel, {24'h308100, a0});
        end
        recv_resp(5, stall, got);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s_resp got=%h required %h", name, got, exp);
        end
        check_idle(name);
    endtask

    task automatic test_write;
        do_write("write", 0, 1'b0);
    endtask

    task automatic test_read;
        do_read("read", 8'h00, 0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 40'h00_0000_1234);
    endtask

    task automatic test_err;
        do_read("err", 8'h08, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 40'h01_0000_0000);
    endtask

    task automatic test_badop;
        logic [39:0] got;
        cyc_seen = 1'b0;
        send_byte(8'hAA);
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL badop_state tx_valid=%b busy=%b rx_ready=%b required 1 1 0", tx_valid, busy, rx_ready);
        end
        recv_resp(1, 1'b0, got);
        checks++;
        if (got[7:0] !== 8'h03 || cyc_seen !== 1'b0) begin
            fails++;
            $display("FAIL badop_status got=%h cyc_seen=%b required 03 0", got[7:0], cyc_seen);
        end
        check_idle("badop");
        do_read("after_badop", 8'h00, 0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 40'h00_CAFE_0001);
    endtask

    task automatic test_backpressure;
        do_write("bp_write", 2, 1'b1);
        do_read("bp_read", 8'h00, 1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 40'h00_0000_1234);
    endtask

    task automatic test_timeout;
`ifdef WBM_TIMEOUT_EN
        logic [7:0] f[9] = '{8'h57, 8'h30, 8'h80, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [39:0] got;
        int n;
        send_frame(f, 9, 0);
        n = 0;
        while (wbm_cyc && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != TO) begin
            fails++;
            $display("FAIL timeout_len cycles=%0d required %0d", n, TO);
        end
        recv_resp(1, 1'b0, got);
        checks++;
        if (got[7:0] !== 8'h02) begin
            fails++;
            $display("FAIL timeout_status got=%h required 02", got[7:0]);
        end
        check_idle("timeout");
`else
        logic [7:0] f[9] = '{8'h52, 8'h30, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 5, 0);
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (wbm_cyc !== 1'b1 || wbm_stb !== 1'b1 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL hang_hold cyc=%b stb=%b tx_valid=%b required 1 1 0", wbm_cyc, wbm_stb, tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_drop cyc=%b stb=%b busy=%b required 0 0 0", wbm_cyc, wbm_stb, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check_idle("after_abort");
`endif
    endtask

    task automatic test_midframe_reset;
        send_byte(8'h52);
        send_byte(8'h30);
        send_byte(8'h81);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL midframe_reset busy=%b rx_ready=%b required 0 0", busy, rx_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_read("after_reset", 8'h00, 0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 40'h00_0000_1234);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_err();
        test_badop();
        test_backpressure();
        test_timeout();
        test_midframe_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
